// File: rtl/ewrapper_tx_framer.sv
// Frames emesh transactions into transposed 72-bit words (8 data pins + frame pin, 8 slots per beat).
// Optional burst beats (DATA-only continuation words) are built when TX_FRAMER_BURST_EN is defined.
//
// state | meaning
// IDLE  | no frame in flight, output idle word, accepting
// C0    | first beat of a frame (header, dst, data[31:8]); not accepting
// C1    | second beat (data[7:0], src); accepting the next txn
// B     | burst continuation beat (data only); accepting the next txn
module ewrapper_tx_framer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK_DIV_IN,
    input  logic        RESET_N,
    input  logic        EMESH_ACCESS,
    input  logic        EMESH_WRITE,
    input  logic [1:0]  EMESH_DATAMODE,
    input  logic [3:0]  EMESH_CTRLMODE,
    input  logic [31:0] EMESH_DSTADDR,
    input  logic [31:0] EMESH_DATA,
    input  logic [31:0] EMESH_SRCADDR,
    output logic        EMESH_WAIT,
    input  logic        TX_RD_WAIT,
    output logic [71:0] DATA_OUT_FROM_DEVICE
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_C0   = 2'd1;
    localparam logic [1:0] ST_C1   = 2'd2;
    localparam logic [1:0] ST_B    = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [7:0]             hdr_q, hdr_d;
    logic [31:0]            dst_q, dst_d;
    logic [31:0]            data_q, data_d;
    logic [31:0]            src_q, src_d;
    logic [71:0]            dout_q, dout_d;

    logic                   wait_sync;
    logic                   accept_window;
    logic                   accept;
    logic                   burst_ok;
    logic [7:0][7:0]        slots;
    logic [7:0]             frame;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], TX_RD_WAIT};
    end

    assign wait_sync     = sync_q[SYNC_STAGES-1];
    assign accept_window = (state_q != ST_C0);
    assign EMESH_WAIT    = wait_sync | ~accept_window;
    assign accept        = EMESH_ACCESS & ~EMESH_WAIT;

`ifdef TX_FRAMER_BURST_EN
    // hdr_q/dst_q hold the previously accepted txn: {ctrl[7:4], mode[3:2], write[1], 0}
    always_comb begin
        burst_ok = ((state_q == ST_C1) || (state_q == ST_B))
                 && EMESH_WRITE && hdr_q[1]
                 && (EMESH_DATAMODE == 2'b10) && (hdr_q[3:2] == 2'b10)
                 && (EMESH_CTRLMODE == hdr_q[7:4])
                 && (EMESH_DSTADDR == (dst_q + 32'd4));
    end
`else
    assign burst_ok = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        dst_d   = dst_q;
        data_d  = data_q;
        src_d   = src_q;
        if (accept) begin
            hdr_d   = {EMESH_CTRLMODE, EMESH_DATAMODE, EMESH_WRITE, 1'b0};
            dst_d   = EMESH_DSTADDR;
            data_d  = EMESH_DATA;
            src_d   = EMESH_SRCADDR;
            state_d = burst_ok ? ST_B : ST_C0;
        end else begin
            case (state_q)
                ST_C0:   state_d = ST_C1;
                ST_C1:   state_d = ST_IDLE;
                ST_B:    state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // The word is built from the state being entered so an accept shows up one edge later.
    always_comb begin
        slots = '0;
        frame = 8'h00;
        case (state_d)
            ST_C0: begin
                slots = {hdr_d, dst_d, data_d[31:8]};
                frame = 8'hFF;
            end
            ST_C1: begin
                slots = {data_d[7:0], src_d, 24'h0};
                frame = 8'hFF;
            end
            ST_B: begin
                slots = {data_d, 32'h0};
                frame = 8'hFF;
            end
            default: begin
                slots = '0;
                frame = 8'h00;
            end
        endcase
    end

    // Slot 0 sits in slots[7]; pin p carries bit p of every slot, slot 0 at the pin's MSB.
    always_comb begin
        dout_d = '0;
        for (int e = 0; e < 8; e++) begin
            for (int p = 0; p < 8; p++) begin
                dout_d[8*p + 7 - e] = slots[7-e][p];
            end
            dout_d[71 - e] = frame[e];
        end
    end

    always_ff @(posedge CLK_DIV_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            sync_q  <= '1;
            hdr_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            src_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            hdr_q   <= hdr_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
            src_q   <= src_d;
            dout_q  <= dout_d;
        end
    end

    assign DATA_OUT_FROM_DEVICE = dout_q;

endmodule

// File: tb/tb_ewrapper_tx_framer.sv
// Directed self-checking bench for ewrapper_tx_framer; expectations branch on TX_FRAMER_BURST_EN.
module tb_ewrapper_tx_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        acc, wr;
    logic [1:0]  mode;
    logic [3:0]  ctrl;
    logic [31:0] dst, data, src;
    logic        emesh_wait;
    logic        tx_rd_wait;
    logic [71:0] dout;

    int total = 0;
    int bad   = 0;

    ewrapper_tx_framer #(.SYNC_STAGES(2)) dut (
        .CLK_DIV_IN           (clk),
        .RESET_N              (rst_n),
        .EMESH_ACCESS         (acc),
        .EMESH_WRITE          (wr),
        .EMESH_DATAMODE       (mode),
        .EMESH_CTRLMODE       (ctrl),
        .EMESH_DSTADDR        (dst),
        .EMESH_DATA           (data),
        .EMESH_SRCADDR        (src),
        .EMESH_WAIT           (emesh_wait),
        .TX_RD_WAIT           (tx_rd_wait),
        .DATA_OUT_FROM_DEVICE (dout)
    );

    always #5 clk = ~clk;

    // s = {slot0, slot1, ..., slot7}; pin p bit (7-e) carries bit p of slot e.
    function automatic logic [71:0] mk(input logic [63:0] s, input logic [7:0] fr);
        logic [71:0] w;
        logic [7:0]  b;
        w = '0;
        for (int e = 0; e < 8; e++) begin
            b = s[63-8*e -: 8];
            for (int p = 0; p < 8; p++) w[8*p + 7 - e] = b[p];
            w[71 - e] = fr[e];
        end
        return w;
    endfunction

    function automatic logic [71:0] w_c0(input logic [7:0] h, input logic [31:0] d, input logic [31:0] x);
        return mk({h, d, x[31:8]}, 8'hFF);
    endfunction

    function automatic logic [71:0] w_c1(input logic [31:0] x, input logic [31:0] s);
        return mk({x[7:0], s, 24'h0}, 8'hFF);
    endfunction

    function automatic logic [71:0] w_b(input logic [31:0] x);
        return mk({x, 32'h0}, 8'hFF);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_txn(input logic a, input logic w, input logic [1:0] m, input logic [3:0] c,
                           input logic [31:0] d, input logic [31:0] x, input logic [31:0] s);
        acc = a; wr = w; mode = m; ctrl = c; dst = d; data = x; src = s;
    endtask

    task automatic set_idle();
        set_txn(1'b0, 1'b0, 2'b00, 4'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic chk_w(input string tag, input logic [71:0] exp);
        total++;
        assert (dout === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, dout, exp);
        end
    endtask

    task automatic chk_wait(input string tag, input logic exp);
        total++;
        assert (emesh_wait === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, emesh_wait, exp);
        end
    endtask

    logic [1:0]  rd_mode [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [3:0]  rd_ctrl [4] = '{4'h3, 4'h5, 4'hF, 4'h9};
    logic [7:0]  rd_hdr  [4] = '{8'h30, 8'h54, 8'hF8, 8'h9C};
    logic [31:0] rd_dst  [4] = '{32'h1111_2222, 32'hA0B0_C0D0, 32'h0000_00FF, 32'hFFFF_FFFC};
    logic [31:0] rd_dat  [4] = '{32'h0102_0304, 32'h5A5A_A5A5, 32'hFFFF_FFFF, 32'h8000_0001};
    logic [31:0] rd_src  [4] = '{32'h4433_2211, 32'h0000_0000, 32'hCAFE_F00D, 32'h1357_9BDF};

    initial begin
        rst_n      = 1'b0;
        tx_rd_wait = 1'b0;
        set_idle();

        // Reset held while inputs toggle
        for (int i = 0; i < 4; i++) begin
            set_txn(1'b1, i[0], i[1:0], 4'(i), $urandom, $urandom, $urandom);
            tick();
            chk_w("rst_dout", 72'h0);
            chk_wait("rst_wait", 1'b1);
        end
        set_idle();
        rst_n = 1'b1;
        tick();
        chk_wait("rel_wait_1", 1'b1);
        tick();
        chk_wait("rel_wait_2", 1'b0);
        chk_w("rel_dout", 72'h0);

        // Single write
        set_txn(1'b1, 1'b1, 2'b10, 4'h0, 32'h8080_0000, 32'hDEAD_BEEF, 32'h0000_1234);
        tick();
        chk_w("wr_c0", mk(64'h0A80_8000_00DE_ADBE, 8'hFF));
        chk_wait("wr_c0_wait", 1'b1);
        set_idle();
        tick();
        chk_w("wr_c1", mk(64'hEF00_0012_3400_0000, 8'hFF));
        chk_wait("wr_c1_wait", 1'b0);
        tick();
        chk_w("wr_idle", 72'h0);

        // Four back-to-back reads with ACCESS held
        for (int i = 0; i < 4; i++) begin
            set_txn(1'b1, 1'b0, rd_mode[i], rd_ctrl[i], rd_dst[i], rd_dat[i], rd_src[i]);
            tick();
            chk_w("rd_c0", w_c0(rd_hdr[i], rd_dst[i], rd_dat[i]));
            chk_wait("rd_c0_wait", 1'b1);
            tick();
            chk_w("rd_c1", w_c1(rd_dat[i], rd_src[i]));
            chk_wait("rd_c1_wait", 1'b0);
        end
        set_idle();
        tick();
        chk_w("rd_idle", 72'h0);

        // Remote wait rises mid-frame
        set_txn(1'b1, 1'b1, 2'b10, 4'h2, 32'h0000_4000, 32'h1234_5678, 32'h9ABC_DEF0);
        tick();
        chk_w("rw_c0", w_c0(8'h2A, 32'h0000_4000, 32'h1234_5678));
        set_idle();
        tx_rd_wait = 1'b1;
        tick();
        chk_w("rw_c1", w_c1(32'h1234_5678, 32'h9ABC_DEF0));
        chk_wait("rw_c1_wait", 1'b0);
        tick();
        chk_w("rw_idle", 72'h0);
        chk_wait("rw_idle_wait", 1'b1);
        set_txn(1'b1, 1'b1, 2'b00, 4'h1, 32'h0BAD_0000, 32'h0F0F_0F0F, 32'h0000_0077);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_w("rw_held_dout", 72'h0);
            chk_wait("rw_held_wait", 1'b1);
        end
        tx_rd_wait = 1'b0;
        tick();
        chk_w("rw_rel1_dout", 72'h0);
        chk_wait("rw_rel1_wait", 1'b1);
        tick();
        chk_w("rw_rel2_dout", 72'h0);
        chk_wait("rw_rel2_wait", 1'b0);
        tick();
        chk_w("rw_c0b", w_c0(8'h12, 32'h0BAD_0000, 32'h0F0F_0F0F));
        set_idle();
        tick();
        chk_w("rw_c1b", w_c1(32'h0F0F_0F0F, 32'h0000_0077));
        tick();
        chk_w("rw_idle2", 72'h0);

        // Sub-cycle wait pulse straddling one edge
        #6 tx_rd_wait = 1'b1;
        #5 tx_rd_wait = 1'b0;
        chk_wait("pulse_wait_0", 1'b0);
        tick();
        chk_wait("pulse_wait_1", 1'b1);
        set_txn(1'b1, 1'b0, 2'b01, 4'h7, 32'h2468_ACE0, 32'h1122_3344, 32'h5566_7788);
        tick();
        chk_w("pulse_dout", 72'h0);
        chk_wait("pulse_wait_2", 1'b0);
        tick();
        chk_w("pulse_c0", w_c0(8'h74, 32'h2468_ACE0, 32'h1122_3344));
        set_idle();
        tick();
        chk_w("pulse_c1", w_c1(32'h1122_3344, 32'h5566_7788));
        tick();
        chk_w("pulse_idle", 72'h0);

        // Reset during C1 with a txn pending
        set_txn(1'b1, 1'b1, 2'b10, 4'hC, 32'h3000_0000, 32'hAAAA_5555, 32'h0000_0001);
        tick();
        chk_w("mr_c0", w_c0(8'hCA, 32'h3000_0000, 32'hAAAA_5555));
        set_txn(1'b1, 1'b1, 2'b10, 4'hC, 32'h3000_0004, 32'h7777_8888, 32'h0000_0002);
        tick();
        chk_w("mr_c1", w_c1(32'hAAAA_5555, 32'h0000_0001));
        #1 rst_n = 1'b0;
        #1;
        chk_w("mr_async_dout", 72'h0);
        chk_wait("mr_async_wait", 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        chk_w("mr_rel1_dout", 72'h0);
        chk_wait("mr_rel1_wait", 1'b1);
        set_idle();
        tick();
        chk_w("mr_rel2_dout", 72'h0);
        chk_wait("mr_rel2_wait", 1'b0);
        set_txn(1'b1, 1'b0, 2'b00, 4'h6, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030);
        tick();
        chk_w("mr_restart_c0", w_c0(8'h60, 32'h0000_0010, 32'h0000_0020));
        set_idle();
        tick();
        chk_w("mr_restart_c1", w_c1(32'h0000_0020, 32'h0000_0030));
        tick();
        chk_w("mr_restart_idle", 72'h0);

        // Incrementing writes: burst chain when enabled, plain frames otherwise
        set_txn(1'b1, 1'b1, 2'b10, 4'h0, 32'h0000_0100, 32'hD000_0000, 32'h0000_0ABC);
        tick();
        chk_w("bu_c0_0", w_c0(8'h0A, 32'h0000_0100, 32'hD000_0000));
        tick();
        chk_w("bu_c1_0", w_c1(32'hD000_0000, 32'h0000_0ABC));
        chk_wait("bu_c1_wait", 1'b0);
        set_txn(1'b1, 1'b1, 2'b10, 4'h0, 32'h0000_0104, 32'hD111_1111, 32'h0000_0ABC);
`ifdef TX_FRAMER_BURST_EN
        tick();
        chk_w("bu_b1", w_b(32'hD111_1111));
        chk_wait("bu_b1_wait", 1'b0);
        set_txn(1'b1, 1'b1, 2'b10, 4'h0, 32'h0000_0108, 32'hD222_2222, 32'h0000_0ABC);
        tick();
        chk_w("bu_b2", w_b(32'hD222_2222));
        chk_wait("bu_b2_wait", 1'b0);
`else
        tick();
        chk_w("bu_c0_1", w_c0(8'h0A, 32'h0000_0104, 32'hD111_1111));
        tick();
        chk_w("bu_c1_1", w_c1(32'hD111_1111, 32'h0000_0ABC));
        set_txn(1'b1, 1'b1, 2'b10, 4'h0, 32'h0000_0108, 32'hD222_2222, 32'h0000_0ABC);
        tick();
        chk_w("bu_c0_2", w_c0(8'h0A, 32'h0000_0108, 32'hD222_2222));
        tick();
        chk_w("bu_c1_2", w_c1(32'hD222_2222, 32'h0000_0ABC));
`endif
        set_txn(1'b1, 1'b1, 2'b10, 4'h0, 32'h0000_0110, 32'hD333_3333, 32'h0000_0ABC);
        tick();
        chk_w("bu_c0_3", w_c0(8'h0A, 32'h0000_0110, 32'hD333_3333));
        chk_wait("bu_c0_3_wait", 1'b1);
        set_idle();
        tick();
        chk_w("bu_c1_3", w_c1(32'hD333_3333, 32'h0000_0ABC));
        tick();
        chk_w("bu_idle", 72'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
